gamepad_poller_apb: RTL and testbench



---
 rtl/gamepad_pkg.sv | 27 ++
 rtl/pad_tick_div.sv | 24 ++
 rtl/gamepad_poller_apb.sv | 159 +++++++++++++++
 tb/tb_gamepad_poller_apb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pkg.sv
// rtl/gamepad_pkg.sv - shared constants and FSM encoding for the gamepad poller
package gamepad_pkg;

   localparam logic [11:0] ADDR_CTRL       = 12'h000;
   localparam logic [11:0] ADDR_STATUS     = 12'h004;
   localparam logic [11:0] ADDR_STATE_BASE = 12'h010;
   localparam logic [11:0] ADDR_PRESS_BASE = 12'h020;

   localparam int CTRL_EN_BIT = 0;
   localparam int CTRL_IE_BIT = 1;

   localparam int MIN_PADS = 1;
   localparam int MAX_PADS = 4;
   localparam int MIN_BITS = 8;
   localparam int MAX_BITS = 16;
   localparam int MIN_DIV  = 2;
   localparam int MAX_DIV  = 1023;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SAMPLE,
      ST_CLKH,
      ST_COMMIT
   } poll_state_e;

endpackage

// File: rtl/pad_tick_div.sv
// rtl/pad_tick_div.sv - free-running divider, one-cycle tick every DIV PCLK cycles
module pad_tick_div #(
   parameter int DIV = 150
) (
   input  logic PCLK,
   input  logic PRESERN,
   output logic tick
);

   localparam logic [9:0] LAST = 10'(DIV - 1);

   logic [9:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         cnt <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 10'd1;
      end
   end

endmodule

// File: rtl/gamepad_poller_apb.sv
// rtl/gamepad_poller_apb.sv - APB3 slave polling up to four NES-style serial pads
module gamepad_poller_apb
   import gamepad_pkg::*;
#(
   parameter int N_PADS = 2,
   parameter int N_BITS = 8,
   parameter int DIV    = 150
) (
   input  logic              PCLK,
   input  logic              PRESERN,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              pad_latch,
   output logic              pad_clock,
   input  logic [N_PADS-1:0] pad_data,
   output logic              irq
);

   localparam int CW = $clog2(N_BITS);

   if (N_PADS < MIN_PADS || N_PADS > MAX_PADS || N_BITS < MIN_BITS || N_BITS > MAX_BITS ||
       DIV < MIN_DIV || DIV > MAX_DIV) begin : g_bad_cfg
      $error("gamepad_poller_apb: parameter out of range");
   end

   poll_state_e       state_q, state_d;
   logic [CW-1:0]     bit_cnt;
   logic              tick, sample_en, commit, last_bit;
   logic              ctrl_en, ctrl_ie, any_press;
   logic [15:0]       frame_cnt;
   logic [N_BITS-1:0] shift_q  [N_PADS];
   logic [N_BITS-1:0] state_r  [N_PADS];
   logic [N_BITS-1:0] press_q  [N_PADS];
   logic [N_BITS-1:0] w1c_mask [N_PADS];
   logic [11:0]       addr;
   logic              wr_en, rd_setup;
   logic [31:0]       rdata;
   logic              unused_bits;

   assign PREADY      = 1'b1;
   assign PSLVERR     = 1'b0;
   assign addr        = PADDR[11:0];
   assign wr_en       = PSEL & PENABLE & PWRITE;
   assign rd_setup    = PSEL & ~PENABLE & ~PWRITE;
   assign unused_bits = ^{PADDR[31:12], PWDATA[31:N_BITS]};

   pad_tick_div #(.DIV(DIV)) u_div (
      .PCLK   (PCLK),
      .PRESERN(PRESERN),
      .tick   (tick)
   );

   assign last_bit  = (bit_cnt == CW'(N_BITS - 1));
   assign sample_en = (state_q == ST_SAMPLE) && tick;
   assign commit    = (state_q == ST_COMMIT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (tick && ctrl_en) state_d = ST_LATCH;
         ST_LATCH:  if (tick) state_d = ST_SAMPLE;
         ST_SAMPLE: if (tick) state_d = last_bit ? ST_COMMIT : ST_CLKH;
         ST_CLKH:   if (tick) state_d = ST_SAMPLE;
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Strobes come from their own flops so the pad lines never glitch on state decode.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state_q   <= ST_IDLE;
         pad_latch <= 1'b0;
         pad_clock <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         state_q   <= state_d;
         pad_latch <= (state_d == ST_LATCH);
         pad_clock <= (state_d == ST_CLKH);
         if (state_q == ST_LATCH)
            bit_cnt <= '0;
         else if (sample_en)
            bit_cnt <= bit_cnt + CW'(1);
      end
   end

   always_comb begin
      for (int k = 0; k < N_PADS; k++) begin
         w1c_mask[k] = '0;
         if (wr_en && addr == ADDR_PRESS_BASE + 12'(4 * k))
            w1c_mask[k] = PWDATA[N_BITS-1:0];
      end
   end

   // A press detected at COMMIT is OR-ed in after the clear, so it survives a same-cycle W1C.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         for (int k = 0; k < N_PADS; k++) begin
            shift_q[k] <= '0;
            state_r[k] <= '0;
            press_q[k] <= '0;
         end
         frame_cnt <= '0;
         ctrl_en   <= 1'b1;
         ctrl_ie   <= 1'b0;
      end else begin
         for (int k = 0; k < N_PADS; k++) begin
            if (sample_en)
               shift_q[k] <= {shift_q[k][N_BITS-2:0], ~pad_data[k]};
            if (commit)
               state_r[k] <= shift_q[k];
            press_q[k] <= (press_q[k] & ~w1c_mask[k]) |
                          (commit ? (shift_q[k] & ~state_r[k]) : '0);
         end
         if (commit)
            frame_cnt <= frame_cnt + 16'd1;
         if (wr_en && addr == ADDR_CTRL) begin
            ctrl_en <= PWDATA[CTRL_EN_BIT];
            ctrl_ie <= PWDATA[CTRL_IE_BIT];
         end
      end
   end

   always_comb begin
      any_press = 1'b0;
      for (int k = 0; k < N_PADS; k++)
         any_press = any_press | (|press_q[k]);
   end

   assign irq = ctrl_ie & any_press;

   always_comb begin
      rdata = '0;
      if (addr == ADDR_CTRL)
         rdata = {30'd0, ctrl_ie, ctrl_en};
      else if (addr == ADDR_STATUS)
         rdata = {frame_cnt, 15'd0, (state_q != ST_IDLE)};
      for (int k = 0; k < N_PADS; k++) begin
         if (addr == ADDR_STATE_BASE + 12'(4 * k))
            rdata = 32'(state_r[k]);
         if (addr == ADDR_PRESS_BASE + 12'(4 * k))
            rdata = 32'(press_q[k]);
      end
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN)
         PRDATA <= '0;
      else if (rd_setup)
         PRDATA <= rdata;
   end

endmodule

// File: tb/tb_gamepad_poller_apb.sv
// tb/tb_gamepad_poller_apb.sv - directed self-checking bench for gamepad_poller_apb
module tb_gamepad_poller_apb;

   logic        PCLK = 1'b0;
   logic        PRESERN = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PADDR = '0, PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR, pad_latch, pad_clock, irq;
   logic [1:0]  pad_data;

   int checks = 0;
   int passes = 0;

   logic [7:0] pat0 = 8'h7E;
   logic [7:0] pat1 = 8'hFF;
   int         idx  = 0;

   gamepad_poller_apb #(.N_PADS(2), .N_BITS(8), .DIV(4)) dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .pad_latch(pad_latch), .pad_clock(pad_clock), .pad_data(pad_data), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   // 4021-style pad: latch reloads, each shift-clock rising edge advances one bit, MSB first
   always @(posedge pad_latch) idx = 0;
   always @(posedge pad_clock) idx = idx + 1;
   always_comb begin
      pad_data[0] = (idx < 8) ? pat0[7-idx] : 1'b1;
      pad_data[1] = (idx < 8) ? pat1[7-idx] : 1'b1;
   end

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      d = PRDATA;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_latch_rise();
      logic prev = 1'b1;
      bit   ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge PCLK);
         if (pad_latch && !prev) begin ok = 1'b1; break; end
         prev = pad_latch;
      end
      checks++;
      if (!ok) $display("FAIL latch_rise_timeout: got none expected a pad_latch rise");
      else passes++;
   endtask

   task automatic wait_frame(input int target);
      logic [31:0] d;
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         apb_read(32'h004, d);
         if (d[31:16] == 16'(target)) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) $display("FAIL frame_timeout: got frame_cnt %0d expected %0d", d[31:16], target);
      else passes++;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(posedge PCLK);
      #1;
      checks++; if (pad_latch !== 1'b0) $display("FAIL rst_latch: got %b expected 0", pad_latch); else passes++;
      checks++; if (pad_clock !== 1'b0) $display("FAIL rst_clock: got %b expected 0", pad_clock); else passes++;
      checks++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", irq); else passes++;
      checks++; if (PRDATA !== 32'h0) $display("FAIL rst_prdata: got %h expected 0", PRDATA); else passes++;
      checks++; if (PREADY !== 1'b1 || PSLVERR !== 1'b0)
         $display("FAIL rst_ready_err: got %b%b expected 10", PREADY, PSLVERR); else passes++;
      @(negedge PCLK);
      PRESERN = 1'b1;
      apb_read(32'h000, d);
      checks++; if (d !== 32'h1) $display("FAIL rst_ctrl: got %h expected 00000001", d); else passes++;
      apb_read(32'h004, d);
      checks++; if (d[31:16] !== 16'h0) $display("FAIL rst_frame_cnt: got %h expected 0", d[31:16]); else passes++;
      apb_read(32'h010, d);
      checks++; if (d !== 32'h0) $display("FAIL rst_state0: got %h expected 0", d); else passes++;
   endtask

   task automatic test_frame();
      logic [31:0] d;
      wait_frame(1);
      apb_read(32'h010, d);
      checks++; if (d !== 32'h81) $display("FAIL frame_state0: got %h expected 00000081", d); else passes++;
      apb_read(32'h014, d);
      checks++; if (d !== 32'h00) $display("FAIL frame_state1: got %h expected 0", d); else passes++;
      apb_read(32'h020, d);
      checks++; if (d !== 32'h81) $display("FAIL frame_press0: got %h expected 00000081", d); else passes++;
      apb_read(32'h024, d);
      checks++; if (d !== 32'h00) $display("FAIL frame_press1: got %h expected 0", d); else passes++;
      apb_read(32'h018, d);
      checks++; if (d !== 32'h00) $display("FAIL unmapped_read: got %h expected 0", d); else passes++;
   endtask

   task automatic test_irq();
      logic [31:0] d;
      checks++; if (irq !== 1'b0) $display("FAIL irq_ie_off: got %b expected 0", irq); else passes++;
      apb_write(32'h000, 32'h3);
      checks++; if (irq !== 1'b1) $display("FAIL irq_set: got %b expected 1", irq); else passes++;
      apb_write(32'h020, 32'h01);
      apb_read(32'h020, d);
      checks++; if (d !== 32'h80) $display("FAIL w1c_partial: got %h expected 00000080", d); else passes++;
      checks++; if (irq !== 1'b1) $display("FAIL irq_partial: got %b expected 1", irq); else passes++;
      apb_write(32'h020, 32'h80);
      checks++; if (irq !== 1'b0) $display("FAIL irq_cleared: got %b expected 0", irq); else passes++;
      apb_read(32'h020, d);
      checks++; if (d !== 32'h00) $display("FAIL w1c_full: got %h expected 0", d); else passes++;
   endtask

   task automatic test_scope();
      int lp = 1, cp = 0, lrun = 1, crun = 0, badw = 0, ovl = 0, period = 0;
      logic pl = 1'b1, pc;
      wait_latch_rise();
      pc = pad_clock;
      if (pad_clock) ovl++;
      for (int i = 1; i <= 80; i++) begin
         @(negedge PCLK);
         if (pad_latch && !pl) begin period = i; break; end
         if (pad_latch && pad_clock) ovl++;
         if (pad_latch) lrun++;
         if (!pad_latch && pl) begin if (lrun != 4) badw++; lrun = 0; end
         if (pad_clock && !pc) begin cp++; crun = 1; end
         else if (pad_clock) crun++;
         if (!pad_clock && pc && crun != 4) badw++;
         pl = pad_latch; pc = pad_clock;
      end
      checks++; if (lp !== 1 || period == 0) $display("FAIL scope_latch_pulses: got period %0d expected a second latch", period); else passes++;
      checks++; if (cp !== 7) $display("FAIL scope_clock_pulses: got %0d expected 7", cp); else passes++;
      checks++; if (badw !== 0) $display("FAIL scope_width: got %0d bad pulses expected 0", badw); else passes++;
      checks++; if (ovl !== 0) $display("FAIL scope_overlap: got %0d expected 0", ovl); else passes++;
      checks++; if (period < 67 || period > 69) $display("FAIL scope_period: got %0d expected 68", period); else passes++;
   endtask

   task automatic test_en_clear();
      logic [31:0] d;
      logic [15:0] fc0;
      int rises = 0;
      logic pl;
      wait_latch_rise();
      apb_read(32'h004, d);
      fc0 = d[31:16];
      checks++; if (d[0] !== 1'b1) $display("FAIL en_busy_mid: got %b expected 1", d[0]); else passes++;
      repeat (15) @(posedge PCLK);
      apb_write(32'h000, 32'h2);
      pl = pad_latch;
      for (int i = 0; i < 420; i++) begin
         @(negedge PCLK);
         if (pad_latch && !pl) rises++;
         pl = pad_latch;
      end
      checks++; if (rises !== 0) $display("FAIL en_no_latch: got %0d rises expected 0", rises); else passes++;
      apb_read(32'h004, d);
      checks++; if (d[0] !== 1'b0) $display("FAIL en_busy_fell: got %b expected 0", d[0]); else passes++;
      checks++; if (d[31:16] !== fc0 + 16'd1) $display("FAIL en_frame_cnt: got %0d expected %0d", d[31:16], fc0 + 16'd1); else passes++;
   endtask

   task automatic test_w1c_collide();
      logic [31:0] d;
      pat1 = 8'hFE;
      apb_write(32'h000, 32'h1);
      wait_latch_rise();
      repeat (62) @(posedge PCLK);
      apb_write(32'h024, 32'h01);
      apb_read(32'h024, d);
      checks++; if (d !== 32'h01) $display("FAIL w1c_collide_press1: got %h expected 00000001", d); else passes++;
      apb_read(32'h014, d);
      checks++; if (d !== 32'h01) $display("FAIL w1c_collide_state1: got %h expected 00000001", d); else passes++;
      apb_write(32'h000, 32'h3);
      checks++; if (irq !== 1'b1) $display("FAIL w1c_collide_irq: got %b expected 1", irq); else passes++;
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      logic pc = 1'b1;
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge PCLK);
         if (pad_clock && !pc) begin ok = 1'b1; break; end
         pc = pad_clock;
      end
      checks++; if (!ok) $display("FAIL clkh_timeout: got none expected a pad_clock rise"); else passes++;
      #1 PRESERN = 1'b0;
      #1;
      checks++; if (pad_clock !== 1'b0) $display("FAIL async_rst_clock: got %b expected 0", pad_clock); else passes++;
      checks++; if (irq !== 1'b0) $display("FAIL async_rst_irq: got %b expected 0", irq); else passes++;
      @(negedge PCLK);
      @(negedge PCLK);
      PRESERN = 1'b1;
      apb_read(32'h004, d);
      checks++; if (d !== 32'h0) $display("FAIL mid_rst_status: got %h expected 0", d); else passes++;
      apb_read(32'h010, d);
      checks++; if (d !== 32'h0) $display("FAIL mid_rst_state0: got %h expected 0", d); else passes++;
      apb_read(32'h014, d);
      checks++; if (d !== 32'h0) $display("FAIL mid_rst_state1: got %h expected 0", d); else passes++;
      apb_read(32'h020, d);
      checks++; if (d !== 32'h0) $display("FAIL mid_rst_press0: got %h expected 0", d); else passes++;
      apb_read(32'h024, d);
      checks++; if (d !== 32'h0) $display("FAIL mid_rst_press1: got %h expected 0", d); else passes++;
      apb_read(32'h000, d);
      checks++; if (d !== 32'h1) $display("FAIL mid_rst_ctrl: got %h expected 00000001", d); else passes++;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_irq();
      test_scope();
      test_en_clear();
      test_w1c_collide();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
